// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//
// Purpose:
//   Bundles every signal the UART transmit frame sequencer exchanges with the
//   outside world, apart from clock and reset. One interface covers two
//   neighbours: the host side (P_DATA / DATA_VALID / parity configuration)
//   and the 8-bit serializer side (ser_en / ser_done / ser_data). The
//   serial line and the status flags are grouped here as well.
//
// Signal summary:
//   P_DATA      [DATA_WIDTH]  parallel byte offered by the host
//   DATA_VALID  1             byte request, honoured only while Busy=0
//   PAR_EN      1             1 = insert a parity bit in the frame
//   PAR_TYP     1             0 = even parity, 1 = odd parity
//   ser_done    1             serializer flag, high on its 8th shift cycle
//   ser_data    1             serializer output bit (LSB of its register)
//   ser_en      1             serializer shift enable
//   Busy        1             frame in progress; blocks serializer reload
//   TX_OUT      1             serial line, idle high
//   frame_done  1             one-cycle pulse in the final stop-bit cycle
//
// Modports:
//   master - the environment: host plus serializer (drives requests and
//            serializer feedback, observes the sequencer outputs)
//   slave  - the uart_tx_ctrl sequencer itself
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_done;
    logic                  ser_data;
    logic                  ser_en;
    logic                  Busy;
    logic                  TX_OUT;
    logic                  frame_done;

    // Environment view: host request lines and serializer feedback are
    // driven from outside, sequencer outputs are observed.
    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        output ser_done,
        output ser_data,
        input  ser_en,
        input  Busy,
        input  TX_OUT,
        input  frame_done
    );

    // Sequencer view: the mirror image of the master modport.
    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        input  ser_done,
        input  ser_data,
        output ser_en,
        output Busy,
        output TX_OUT,
        output frame_done
    );

endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Purpose:
//   Frame sequencer for the UART transmit path. When idle it accepts a
//   parallel byte, captures the parity configuration and the parity bit,
//   then walks the serial line through start, data, optional parity and
//   stop bits, one bit per clock. The data bits themselves come from an
//   external 8-bit serializer that loads P_DATA on the acceptance edge and
//   shifts while ser_en is high; this block only gates that serializer and
//   multiplexes the line.
//
// Ports:
//   CLK     input   bit clock, one UART bit per cycle
//   RST     input   asynchronous, active-low reset
//   io_bus  slave   uart_tx_ctrl_if bundle (host request, parity config,
//                   serializer handshake, TX_OUT, Busy, frame_done)
//
// Parameters:
//   DATA_WIDTH  width of P_DATA used for the parity calculation. The
//               serializer frame itself is always 8 data bits long.
//
// Build option:
//   UART_TX_TWO_STOP_EN  when defined, every frame ends with two stop bits
//                        (STOP followed by STOP2) and frame_done moves to
//                        the second one. When undefined, one stop bit.
//
// Frame timeline, counted from the START cycle:
//   no parity : START, D0..D7, STOP               -> 10 cycles
//   parity    : START, D0..D7, PARITY, STOP       -> 11 cycles
//   (one extra cycle each with UART_TX_TWO_STOP_EN)
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    uart_tx_ctrl_if.slave       io_bus
);

    // Frame phases. STOP2 exists only in the two-stop-bit build.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
        STOP   = 3'd4,
        STOP2  = 3'd5
`else
        STOP   = 3'd4
`endif
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    // Configuration captured at acceptance so that host-side changes while
    // a frame is on the line cannot disturb it.
    logic                  r_parEn;
    logic                  r_parity;

    logic [DATA_WIDTH-1:0] w_pData;
    logic                  w_accept;
    logic                  w_parityCalc;

    assign w_pData = io_bus.P_DATA;

    // A request is only taken in IDLE; in every other state DATA_VALID is
    // ignored, which also gives the mandatory idle gap between frames.
    assign w_accept = (r_state == IDLE) && io_bus.DATA_VALID;

    // XOR-reducing the byte gives 1 for an odd number of ones, which is
    // already the even-parity bit; XOR with PAR_TYP flips it for odd parity.
    assign w_parityCalc = (^w_pData) ^ io_bus.PAR_TYP;

    // State register. Reset is asynchronous so a mid-frame reset drops the
    // line back to idle-high immediately rather than on the next edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Configuration and parity capture on the acceptance edge only. The
    // serializer loads P_DATA on the very same edge, so the parity bit and
    // the shifted data always describe the same byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_parEn  <= 1'b0;
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parEn  <= io_bus.PAR_EN;
            r_parity <= w_parityCalc;
        end
    end

    // Next-state logic. The DATA phase length is owned by the serializer:
    // its ser_done flag marks the eighth shift, so no local bit counter is
    // needed. ser_done is only looked at while in DATA.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (io_bus.DATA_VALID) begin
                    w_nextState = START;
                end
            end
            START: begin
                w_nextState = DATA;
            end
            DATA: begin
                if (io_bus.ser_done) begin
                    if (r_parEn) begin
                        w_nextState = PARITY;
                    end else begin
                        w_nextState = STOP;
                    end
                end
            end
            PARITY: begin
                w_nextState = STOP;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                w_nextState = STOP2;
            end
            STOP2: begin
                w_nextState = IDLE;
            end
`else
            STOP: begin
                w_nextState = IDLE;
            end
`endif
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Output decode. Everything is a function of the registered state,
    // except TX_OUT in DATA which passes the serializer bit straight
    // through. ser_en is high only in DATA so the serializer's own bit
    // counter is cleared in every gap between frames.
    always_comb begin
        io_bus.TX_OUT     = 1'b1;
        io_bus.Busy       = 1'b0;
        io_bus.ser_en     = 1'b0;
        io_bus.frame_done = 1'b0;
        case (r_state)
            IDLE: begin
                io_bus.TX_OUT = 1'b1;
            end
            START: begin
                io_bus.TX_OUT = 1'b0;
                io_bus.Busy   = 1'b1;
            end
            DATA: begin
                io_bus.TX_OUT = io_bus.ser_data;
                io_bus.Busy   = 1'b1;
                io_bus.ser_en = 1'b1;
            end
            PARITY: begin
                io_bus.TX_OUT = r_parity;
                io_bus.Busy   = 1'b1;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                io_bus.TX_OUT = 1'b1;
                io_bus.Busy   = 1'b1;
            end
            STOP2: begin
                io_bus.TX_OUT     = 1'b1;
                io_bus.Busy       = 1'b1;
                io_bus.frame_done = 1'b1;
            end
`else
            STOP: begin
                io_bus.TX_OUT     = 1'b1;
                io_bus.Busy       = 1'b1;
                io_bus.frame_done = 1'b1;
            end
`endif
            default: begin
                io_bus.TX_OUT = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//
// Purpose:
//   Self-checking bench for uart_tx_ctrl. Contains a behavioural model of
//   the 8-bit serializer that sits beside the sequencer, a scoreboard of
//   expected per-cycle line/flag values built from each accepted request,
//   a table of single-frame vectors, and hand-written sequences for reset
//   during a frame and for back-to-back frames with DATA_VALID held high.
//
// Build option:
//   UART_TX_TWO_STOP_EN  must match the RTL build; adds one stop cycle to
//                        every expected frame.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic CLK = 1'b0;
    logic RST;

    uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .io_bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    // Expected values for one Busy cycle.
    typedef struct packed {
        logic tx;
        logic busy;
        logic en;
        logic done;
    } beat_t;

    beat_t expQ[$];

    int checks   = 0;
    int failures = 0;

    // Serializer model: loads on the acceptance edge, shifts right while
    // enabled, raises ser_done on its 8th enabled cycle, counter clears
    // whenever the enable is low. Control bits are sampled mid-cycle.
    logic [7:0] shReg;
    logic [3:0] bitCnt;
    logic       loadNext = 1'b0;
    logic       enSample = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            shReg  <= 8'h00;
            bitCnt <= 4'd0;
        end else begin
            if (loadNext) begin
                shReg <= bus.P_DATA;
            end else if (enSample) begin
                shReg <= shReg >> 1;
            end
            bitCnt <= enSample ? bitCnt + 4'd1 : 4'd0;
        end
    end

    assign bus.ser_data = shReg[0];
    assign bus.ser_done = bus.ser_en && (bitCnt == 4'd7);

    function automatic void checkBit(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void checkInt(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Build the expected frame from the request as the host presented it.
    task automatic pushFrame(input logic [7:0] data, input logic parEn, input logic parTyp);
        int   ones;
        logic p;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            if (data[i]) ones++;
        end
        p = ((ones % 2) == 1) ^ parTyp;
        expQ.push_back('{tx: 1'b0, busy: 1'b1, en: 1'b0, done: 1'b0});
        for (int i = 0; i < 8; i++) begin
            expQ.push_back('{tx: data[i], busy: 1'b1, en: 1'b1, done: 1'b0});
        end
        if (parEn) begin
            expQ.push_back('{tx: p, busy: 1'b1, en: 1'b0, done: 1'b0});
        end
`ifdef UART_TX_TWO_STOP_EN
        expQ.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b0, done: 1'b0});
`endif
        expQ.push_back('{tx: 1'b1, busy: 1'b1, en: 1'b0, done: 1'b1});
    endtask

    // One mid-cycle observation: reset, scoreboard pop, or idle + accept.
    task automatic monitorCycle();
        beat_t e;
        @(negedge CLK);
        enSample = bus.ser_en;
        loadNext = 1'b0;
        if (!RST) begin
            expQ.delete();
            checkBit("rst_tx", bus.TX_OUT, 1'b1);
            checkBit("rst_busy", bus.Busy, 1'b0);
            checkBit("rst_en", bus.ser_en, 1'b0);
        end else if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkBit("frame_tx", bus.TX_OUT, e.tx);
            checkBit("frame_busy", bus.Busy, e.busy);
            checkBit("frame_en", bus.ser_en, e.en);
            checkBit("frame_done", bus.frame_done, e.done);
        end else begin
            checkBit("idle_tx", bus.TX_OUT, 1'b1);
            checkBit("idle_busy", bus.Busy, 1'b0);
            checkBit("idle_en", bus.ser_en, 1'b0);
            checkBit("idle_done", bus.frame_done, 1'b0);
            if (bus.DATA_VALID === 1'b1) begin
                pushFrame(bus.P_DATA, bus.PAR_EN, bus.PAR_TYP);
                loadNext = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp);
        @(posedge CLK);
        #1;
        bus.P_DATA     = data;
        bus.PAR_EN     = parEn;
        bus.PAR_TYP    = parTyp;
        bus.DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.DATA_VALID = 1'b0;
    endtask

    // Send one frame and record the line during Busy. disturbAt >= 0 flips
    // all host inputs after that many frame cycles.
    task automatic runFrame(input logic [7:0] data, input logic parEn, input logic parTyp,
                            input int disturbAt,
                            output int len, output logic [15:0] bits, output int doneAt);
        applyStimulus(data, parEn, parTyp);
        len    = 0;
        bits   = 16'h0;
        doneAt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!bus.Busy) break;
            bits[len] = bus.TX_OUT;
            len++;
            if (bus.frame_done) doneAt = len;
            if (c == disturbAt) begin
                #2;
                bus.P_DATA  = ~bus.P_DATA;
                bus.PAR_EN  = ~bus.PAR_EN;
                bus.PAR_TYP = ~bus.PAR_TYP;
            end
        end
    endtask

    task automatic checkOutput(input string name, input int len, input logic [15:0] bits,
                               input int doneAt, input int expLen,
                               input logic parEn, input logic expPar);
        checkInt({name, "_len"}, len, expLen);
        checkInt({name, "_done_cycle"}, doneAt, expLen);
        if (parEn) begin
            checkBit({name, "_parity"}, bits[9], expPar);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       parEn;
        logic       parTyp;
        int         expLen;
        logic       expPar;
        int         disturbAt;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog timeout at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          len;
        int          doneAt;
        logic [15:0] bits;
        int          starts[$];
        logic        prevBusy;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 10 + EXTRA, 1'b0, -1};
        vecs[1] = '{8'hA5, 1'b1, 1'b0, 11 + EXTRA, 1'b0, -1};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 11 + EXTRA, 1'b1, 4};
        vecs[3] = '{8'h01, 1'b1, 1'b0, 11 + EXTRA, 1'b1, -1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 11 + EXTRA, 1'b1, -1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 11 + EXTRA, 1'b0, 6};
        vecs[6] = '{8'h3C, 1'b0, 1'b1, 10 + EXTRA, 1'b0, 3};

        bus.P_DATA     = 8'h00;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b0;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        #1;
        checkBit("reset_tx", bus.TX_OUT, 1'b1);
        checkBit("reset_busy", bus.Busy, 1'b0);
        checkBit("reset_en", bus.ser_en, 1'b0);
        checkBit("reset_done", bus.frame_done, 1'b0);

        fork
            forever monitorCycle();
        join_none

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);

        $display("[TB] single-frame vector table");
        for (int i = 0; i < 7; i++) begin
            runFrame(vecs[i].data, vecs[i].parEn, vecs[i].parTyp, vecs[i].disturbAt,
                     len, bits, doneAt);
            checkOutput($sformatf("vec%0d", i), len, bits, doneAt,
                        vecs[i].expLen, vecs[i].parEn, vecs[i].expPar);
            if (i == 0) begin
                // 0xA5 LSB first: start 0, data 1,0,1,0,0,1,0,1, stop 1
                checkInt("a5_line_bits", int'(bits[9:0]), 32'h34A);
            end
        end

        $display("[TB] reset during data phase");
        applyStimulus(8'h96, 1'b1, 1'b0);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        checkBit("midrst_tx", bus.TX_OUT, 1'b1);
        checkBit("midrst_busy", bus.Busy, 1'b0);
        checkBit("midrst_en", bus.ser_en, 1'b0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        runFrame(8'h5A, 1'b0, 1'b0, -1, len, bits, doneAt);
        checkOutput("post_rst", len, bits, doneAt, 10 + EXTRA, 1'b0, 1'b0);

        $display("[TB] DATA_VALID held high");
        @(posedge CLK);
        #1;
        bus.P_DATA     = 8'h3C;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;
        bus.DATA_VALID = 1'b1;
        prevBusy = 1'b0;
        for (int c = 0; c < 44; c++) begin
            @(negedge CLK);
            if (bus.Busy && !prevBusy) starts.push_back(c);
            prevBusy = bus.Busy;
            if (c == 27) begin
                #2;
                bus.P_DATA = 8'hFF;
            end
        end
        @(posedge CLK);
        #1;
        bus.DATA_VALID = 1'b0;
        checkInt("held_frames", starts.size(), 4);
        for (int k = 0; k < 4 && k < starts.size(); k++) begin
            checkInt($sformatf("held_start%0d", k), starts[k], 1 + k * (11 + EXTRA));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (!bus.Busy) break;
        end
        repeat (3) @(negedge CLK);
        checkInt("queue_empty", expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
